// File: rtl/serial_word_loader_pkg.sv
// Shared types and limits for serial_word_loader.
//   swl_state_e   : FSM state encoding (2 bits).
//   SWL_MAX_WIDTH : largest supported word width.
package serial_word_loader_pkg;

  localparam int unsigned SWL_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b10
  } swl_state_e;

endpackage

// File: rtl/even_parity_chk.sv
// Even-parity checker: the frame passes when the XOR of all word bits and the parity bit is 0.
// Ports:
//   word_i   [WIDTH-1:0] data word
//   parity_i             received parity bit
//   ok_o                 1 when the frame has even parity
module even_parity_chk #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             parity_i,
  output logic             ok_o
);

  assign ok_o = ~((^word_i) ^ parity_i);

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader. Assembles MSB-first qualified serial bits into a WIDTH-bit word
// and presents it on D with a one-cycle load strobe, so the downstream register only ever
// captures complete words.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   sin        serial data bit (MSB first)
//   sin_valid  qualifies sin; one bit consumed per cycle it is high
//   abort      synchronous discard of any partial word (wins over sin_valid)
//   D          last completed word (registered)
//   load       one-cycle strobe when D has just been updated
//   busy       high while a partial word is held
//   parity_err one-cycle strobe on a failing frame
// Build option: define SWL_PARITY_EN to append an even-parity bit to each frame; without it
// parity_err is tied to 0. The port list is the same either way.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             abort,
  output logic [WIDTH-1:0] D,
  output logic             load,
  output logic             busy,
  output logic             parity_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SWL_MAX_WIDTH) begin : gen_bad_width
    $error("serial_word_loader: WIDTH out of range 2..16");
  end

  swl_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] d_q;
  logic             load_q;
  logic [WIDTH-1:0] shift_next;

  assign shift_next = {shreg_q[WIDTH-2:0], sin};

`ifdef SWL_PARITY_EN
  logic parity_ok;
  logic perr_q;

  // shreg_q holds the completed word while waiting for the parity bit on sin.
  even_parity_chk #(
    .WIDTH(WIDTH)
  ) u_parity_chk (
    .word_i  (shreg_q),
    .parity_i(sin),
    .ok_o    (parity_ok)
  );

  assign parity_err = perr_q;
`else
  // The MSB of the shift register is only consumed by the parity path.
  logic unused_shreg_msb;
  assign unused_shreg_msb = shreg_q[WIDTH-1];
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      d_q     <= '0;
      load_q  <= 1'b0;
`ifdef SWL_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // Strobes default low every cycle.
      load_q <= 1'b0;
`ifdef SWL_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (abort) begin
        // Partial word dropped; D keeps its last value.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else if (sin_valid) begin
        unique case (state_q)
          StIdle: begin
            shreg_q <= {{(WIDTH - 1){1'b0}}, sin};
            cnt_q   <= CntW'(1);
            state_q <= StShift;
          end
          StShift: begin
            shreg_q <= shift_next;
            if (cnt_q == LastCnt) begin
`ifdef SWL_PARITY_EN
              cnt_q   <= cnt_q + CntW'(1);
              state_q <= StParity;
`else
              d_q     <= shift_next;
              load_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= StIdle;
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
`ifdef SWL_PARITY_EN
          StParity: begin
            if (parity_ok) begin
              d_q    <= shreg_q;
              load_q <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= StIdle;
          end
`endif
          default: begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign D    = d_q;
  assign load = load_q;
  assign busy = (state_q != StIdle);

endmodule
